// File: rtl/set_job_issuer.sv
// Job initiator for the SET circle-count engine: queues host jobs, issues them one at a time, returns results.
// Optional macro SET_TIMEOUT_EN adds a WAIT-state watchdog (TIMEOUT_CYC cycles, result 8'hFF with res_err).
module set_job_issuer #(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [23:0]                job_central,
  input  logic [11:0]                job_radius,
  input  logic [1:0]                 job_mode,
  input  logic [TAG_W-1:0]           job_tag,
  output logic                       set_en,
  output logic [23:0]                set_central,
  output logic [11:0]                set_radius,
  output logic [1:0]                 set_mode,
  input  logic                       set_busy,
  input  logic                       set_valid,
  input  logic [7:0]                 set_candidate,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [7:0]                 res_candidate,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_err,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  state_t state, state_next;

  logic [23:0]      q_central [DEPTH];
  logic [11:0]      q_radius  [DEPTH];
  logic [1:0]       q_mode    [DEPTH];
  logic [TAG_W-1:0] q_tag     [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          ready_q;
  logic          full, empty, push, pop;
  logic          wait_done;

  // ready_q keeps job_ready low through reset and releases it one cycle later
  assign full      = (fifo_count == CW'(DEPTH));
  assign empty     = (fifo_count == '0);
  assign job_ready = ready_q & ~full;
  assign push      = job_valid & job_ready;
  assign pop       = (state == IDLE) & ~empty & ~set_busy;

`ifdef SET_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       wd_hit;

  assign wd_hit    = (wd_cnt == 8'(TIMEOUT_CYC - 1));
  assign wait_done = set_valid | wd_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd_cnt <= '0;
    else if (state == ISSUE)
      wd_cnt <= '0;
    else if (state == WAIT)
      wd_cnt <= wd_cnt + 8'd1;
  end
`else
  assign wait_done = set_valid;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      q_central[wr_ptr] <= job_central;
      q_radius[wr_ptr]  <= job_radius;
      q_mode[wr_ptr]    <= job_mode;
      q_tag[wr_ptr]     <= job_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      ready_q <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = (q_mode[rd_ptr] == 2'd3) ? RESULT : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_done) state_next = RESULT;
      RESULT:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    set_en    = (state == ISSUE);
    res_valid = (state == RESULT);
  end

  // Engine pins only change when a real job is popped, so mode-3 jobs leave them untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      res_candidate <= '0;
      res_tag       <= '0;
      res_err       <= 1'b0;
    end else if (pop) begin
      res_tag <= q_tag[rd_ptr];
      if (q_mode[rd_ptr] == 2'd3) begin
        res_err       <= 1'b1;
        res_candidate <= 8'd0;
      end else begin
        set_central <= q_central[rd_ptr];
        set_radius  <= q_radius[rd_ptr];
        set_mode    <= q_mode[rd_ptr];
      end
    end else if (state == WAIT && set_valid) begin
      res_candidate <= set_candidate;
      res_err       <= 1'b0;
    end
`ifdef SET_TIMEOUT_EN
    else if (state == WAIT && wd_hit) begin
      res_candidate <= 8'hFF;
      res_err       <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_set_job_issuer.sv
// Directed bench for set_job_issuer with a behavioural 64-cycle SET engine counting lattice points on a 16x16 grid.
module tb_set_job_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [23:0] job_central;
  logic [11:0] job_radius;
  logic [1:0]  job_mode;
  logic [3:0]  job_tag;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy = 1'b0;
  logic        set_valid = 1'b0;
  logic [7:0]  set_candidate = 8'd0;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_candidate;
  logic [3:0]  res_tag;
  logic        res_err;
  logic [2:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;
  int en_count = 0;
  int viol = 0;
  int left = 0;
  logic mute = 1'b0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  set_job_issuer #(.DEPTH(4), .TAG_W(4), .TIMEOUT_CYC(96)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_central(job_central),
    .job_radius(job_radius), .job_mode(job_mode), .job_tag(job_tag),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
    .res_tag(res_tag), .res_err(res_err), .fifo_count(fifo_count)
  );

  function automatic int circle_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int xa, ya, xb, yb, ra, rb, n;
    logic ina, inb;
    xa = int'(c[23:20]); ya = int'(c[19:16]); xb = int'(c[15:12]); yb = int'(c[11:8]);
    ra = int'(r[11:8]);  rb = int'(r[7:4]);
    n = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        ina = ((x-xa)*(x-xa) + (y-ya)*(y-ya)) <= ra*ra;
        inb = ((x-xb)*(x-xb) + (y-yb)*(y-yb)) <= rb*rb;
        case (m)
          2'd1:    n += int'(ina & inb);
          2'd2:    n += int'(ina ^ inb);
          default: n += int'(ina);
        endcase
      end
    return n;
  endfunction

  // Engine model is deliberately not reset by rst so a dropped in-flight job keeps it busy
  always @(posedge clk) begin
    set_valid <= 1'b0;
    prev_en   <= set_en;
    if (set_en) begin
      if (set_busy || prev_en) viol <= viol + 1;
      en_count      <= en_count + 1;
      set_busy      <= 1'b1;
      left          <= 64;
      set_candidate <= 8'(circle_count(set_central, set_radius, set_mode));
    end else if (set_busy) begin
      left <= left - 1;
      if (left == 1) begin
        set_busy <= 1'b0;
        if (!mute) set_valid <= 1'b1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the job was accepted
  task automatic apply_stimulus(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m, input logic [3:0] t);
    int guard;
    job_valid = 1'b1; job_central = c; job_radius = r; job_mode = m; job_tag = t;
    guard = 0;
    while (!job_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check_output("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int guard;
    guard = 0;
    while (!res_valid && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check_output("res_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_set_en();
    int guard;
    guard = 0;
    while (!set_en && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check_output("en_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_result(input logic [7:0] cand, input logic [3:0] tag, input logic err);
    res_ready = 1'b1;
    wait_valid();
    check_output($sformatf("cand_tag%0d", tag), 32'(res_candidate), 32'(cand));
    check_output($sformatf("tag_tag%0d", tag), 32'(res_tag), 32'(tag));
    check_output($sformatf("err_tag%0d", tag), 32'(res_err), 32'(err));
    @(negedge clk);
  endtask

  initial begin
    int e0, cyc;
    logic stable;
    rst = 1'b1; job_valid = 1'b0; job_central = '0; job_radius = '0;
    job_mode = '0; job_tag = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_job_ready", 32'(job_ready), 32'd0);
    check_output("rst_set_en", 32'(set_en), 32'd0);
    check_output("rst_res_valid", 32'(res_valid), 32'd0);
    check_output("rst_fifo_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("job_ready_after_rst", 32'(job_ready), 32'd1);

    $display("[TB] single mode-0 job");
    e0 = en_count;
    apply_stimulus(24'h440000, 12'h300, 2'd0, 4'd5);
    wait_result(8'd29, 4'd5, 1'b0);
    check_output("single_en_pulses", 32'(en_count - e0), 32'd1);

    $display("[TB] fill FIFO while first job stalls in RESULT");
    res_ready = 1'b0;
    apply_stimulus(24'h880000, 12'h000, 2'd0, 4'd1);
    apply_stimulus(24'h880000, 12'h100, 2'd0, 4'd2);
    apply_stimulus(24'h880000, 12'h200, 2'd0, 4'd3);
    apply_stimulus(24'h445400, 12'h110, 2'd1, 4'd4);
    apply_stimulus(24'h445400, 12'h110, 2'd2, 4'd5);
    check_output("full_job_ready", 32'(job_ready), 32'd0);
    check_output("full_fifo_count", 32'(fifo_count), 32'd4);
    job_valid = 1'b1; job_tag = 4'd7; job_mode = 2'd0;
    repeat (2) @(negedge clk);
    job_valid = 1'b0;
    check_output("full_push_ignored", 32'(fifo_count), 32'd4);
    wait_result(8'd1, 4'd1, 1'b0);
    wait_result(8'd5, 4'd2, 1'b0);
    wait_result(8'd13, 4'd3, 1'b0);
    wait_result(8'd2, 4'd4, 1'b0);
    wait_result(8'd6, 4'd5, 1'b0);
    check_output("drained_fifo_count", 32'(fifo_count), 32'd0);
    check_output("busy_violations", 32'(viol), 32'd0);

    $display("[TB] reserved mode");
    e0 = en_count;
    apply_stimulus(24'h000000, 12'h000, 2'd3, 4'd9);
    check_output("mode3_valid_early", 32'(res_valid), 32'd0);
    @(negedge clk);
    check_output("mode3_valid", 32'(res_valid), 32'd1);
    check_output("mode3_err", 32'(res_err), 32'd1);
    check_output("mode3_cand", 32'(res_candidate), 32'd0);
    check_output("mode3_tag", 32'(res_tag), 32'd9);
    @(negedge clk);
    check_output("mode3_no_en", 32'(en_count - e0), 32'd0);

    $display("[TB] result backpressure");
    res_ready = 1'b0;
    apply_stimulus(24'h880000, 12'h100, 2'd0, 4'd1);
    apply_stimulus(24'h880000, 12'h200, 2'd0, 4'd2);
    wait_valid();
    e0 = en_count;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(res_valid && res_candidate == 8'd5 && res_tag == 4'd1 && !res_err)) stable = 1'b0;
    end
    check_output("hold_stable", 32'(stable), 32'd1);
    check_output("hold_no_en", 32'(en_count - e0), 32'd0);
    check_output("hold_fifo_count", 32'(fifo_count), 32'd1);
    wait_result(8'd5, 4'd1, 1'b0);
    wait_result(8'd13, 4'd2, 1'b0);
    check_output("release_one_en", 32'(en_count - e0), 32'd1);

    $display("[TB] reset during WAIT");
    apply_stimulus(24'h440000, 12'h300, 2'd0, 4'd6);
    wait_set_en();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_res_valid", 32'(res_valid), 32'd0);
    check_output("midrst_set_en", 32'(set_en), 32'd0);
    check_output("midrst_fifo_count", 32'(fifo_count), 32'd0);
    check_output("midrst_set_central", 32'(set_central), 32'd0);
    check_output("midrst_job_ready", 32'(job_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    apply_stimulus(24'h880000, 12'h200, 2'd0, 4'd7);
    wait_result(8'd13, 4'd7, 1'b0);
    check_output("final_busy_violations", 32'(viol), 32'd0);

`ifdef SET_TIMEOUT_EN
    $display("[TB] watchdog");
    mute = 1'b1;
    apply_stimulus(24'h880000, 12'h100, 2'd0, 4'd3);
    wait_set_en();
    cyc = 0;
    while (!res_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_output("timeout_latency", 32'(cyc), 32'd97);
    wait_result(8'hFF, 4'd3, 1'b1);
    mute = 1'b0;
`else
    cyc = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
